wb_ram_slave: RTL
=================

Name: wb_ram_slave

Overview:
- Pipelined Wishbone B4 responder: the slave end of the if_wb interface driven by the CPU's instruction and data masters.
- Backs an on-chip word-addressed 32-bit RAM with byte-lane writes.
- Read/write access with a fixed, parameterised response latency, a bounded number of outstanding requests, and in-order ack/err.
- Used as boot/scratch memory on either the instruction or the data bus.

Parameters:
- AW, 12, word-address width; RAM holds 2**AW 32-bit words.
- LATENCY, 2, cycles from accept edge to ack/err pulse; legal 1..8.
- MAX_OUT, 8, maximum accepted-but-unacknowledged requests; legal 1..15.
- LIMIT, 2**AW, number of valid words; word addresses >= LIMIT get err.

Ports:
- clk_i  input  1  system clock, all logic on rising edge.
- rst_i  input  1  synchronous active-high reset.
- bus  if_wb.slave  —  Wishbone slave modport. Members used:
  - cyc (in, 1)
  - stb (in, 1)
  - we (in, 1)
  - adr (in, 32, byte address)
  - sel (in, 4)
  - dat_m (in, 32, write data)
  - dat_s (out, 32, read data)
  - ack (out, 1)
  - err (out, 1)
  - stall (out, 1)

Behaviour:
- Clock and reset: one clock, clk_i; reset rst_i is synchronous, active-high.
- Reset values: ack=0, err=0, dat_s=0, stall=0, outstanding count=0, all latency-pipe slots invalid. RAM contents are not reset.
- Accept condition: cyc & stb & !stall, sampled at the rising edge. Word index = adr[AW+1:2]; adr[1:0] are ignored.
- Out-of-range request (index >= LIMIT): no RAM access; an error token enters the pipe.
- Write accept: for each lane i with sel[i]=1, RAM[index] byte i <= dat_m byte i, committed at the accept edge. sel=0 writes nothing but is still acked.
- Read accept: RAM[index] is read at the accept edge. A read accepted on the cycle after a write to the same word returns the new data; there is no same-cycle conflict because there is a single port.
- Latency pipe: shift register of LATENCY slots, each holding {valid, is_err, is_read, data}. A request accepted at edge N produces ack (or err) high for exactly the cycle following edge N+LATENCY-1, i.e. LATENCY cycles after acceptance. With LATENCY=1, ack is high in the cycle immediately after the accept edge.
- ack and err are registered, mutually exclusive, one pulse per request, strictly in accept order.
- Back-to-back accepts give back-to-back acks with no bubbles.
- dat_s updates only on read acks and holds its last value otherwise (including on write acks and err).
- Outstanding count: +1 on accept, -1 on an emitted ack/err; both in one cycle leaves it unchanged. Width 4 bits.
- stall = (count == MAX_OUT), driven from the register.
  - stall is never asserted while count < MAX_OUT.
  - When MAX_OUT >= LATENCY, stall never asserts.
- cyc low while requests are in flight (master abort): at the next edge all pipe slots are invalidated, count <= 0, and no ack/err is issued for the aborted requests. Writes already committed remain in RAM.
- stb high with cyc low is ignored.
- Reset asserted mid-transaction: same as abort, plus dat_s <= 0. No ack/err appears in the cycle after the reset edge.

Test Plan:
- Single write then read, LATENCY=2: write adr=0x10, sel=F, dat_m=0xDEADBEEF, then read adr=0x10 -> write ack 2 cycles after accept; read ack 2 cycles after accept with dat_s=0xDEADBEEF; err never high.
- Byte lanes: preload word 5 with 0x11223344, then write adr=0x14, sel=0101, dat_m=0xAABBCCDD, then read -> dat_s=0x11BB33DD.
- Stall, LATENCY=4, MAX_OUT=2: stb held high for 6 reads of consecutive words -> stall high after 2 accepts; at most 2 outstanding at any time; 6 in-order acks; total 6 accepts.
- Out of range, AW=4: read adr=0x40 (word 16) -> err pulse after LATENCY cycles, ack stays 0, dat_s unchanged; a following in-range read acks normally.
- Abort: 3 reads accepted, then cyc dropped one cycle later -> no ack/err afterward; count returns to 0; stall=0; a new cycle starting immediately is acked with correct data.
- Reset mid-flight: write accepted, then rst_i pulsed for 1 cycle before its ack -> no ack; dat_s=0; reading that word afterward returns the written data.

Source files
------------

// File: rtl/wb_ram_slave_if.sv
// if_wb: pipelined Wishbone B4 bus between a master and a slave
interface if_wb;
   logic        cyc;
   logic        stb;
   logic        we;
   logic [31:0] adr;
   logic [3:0]  sel;
   logic [31:0] dat_m;
   logic [31:0] dat_s;
   logic        ack;
   logic        err;
   logic        stall;
   modport master (output cyc, stb, we, adr, sel, dat_m, input dat_s, ack, err, stall);
   modport slave (input cyc, stb, we, adr, sel, dat_m, output dat_s, ack, err, stall);
endinterface

// File: rtl/wb_ram_slave.sv
// wb_ram_slave: pipelined Wishbone RAM responder with fixed latency and bounded outstanding requests
module wb_ram_slave #(
   parameter int AW      = 12,
   parameter int LATENCY = 2,
   parameter int MAX_OUT = 8,
   parameter int LIMIT   = 2**AW
) (
   input logic clk_i,
   input logic rst_i,
   if_wb.slave bus
);
   typedef struct packed {
      logic        v;
      logic        e;
      logic        r;
      logic [31:0] d;
   } tok_t;
   logic [31:0]   ram [0:2**AW-1];
   tok_t          p [0:LATENCY-1];
   tok_t          in_t;
   tok_t          last_in;
   logic [3:0]    cnt;
   logic [31:0]   dat_q;
   logic [AW-1:0] idx;
   logic          acc;
   logic          oor;
   assign idx = bus.adr[AW+1:2];
   assign oor = {2'b00, bus.adr[31:2]} >= 32'(LIMIT);
   assign bus.stall = cnt == 4'(MAX_OUT);
   assign acc = bus.cyc & bus.stb & ~bus.stall;
   assign in_t = '{v: acc, e: oor, r: ~bus.we, d: ram[idx]};
   assign bus.ack = p[LATENCY-1].v & ~p[LATENCY-1].e;
   assign bus.err = p[LATENCY-1].v & p[LATENCY-1].e;
   assign bus.dat_s = dat_q;
   if (LATENCY == 1) begin : g_l1
      assign last_in = in_t;
   end else begin : g_ln
      assign last_in = p[LATENCY-2];
   end
   // a request stops counting as outstanding on the edge that raises its ack/err
   always_ff @(posedge clk_i) begin
      if (rst_i || !bus.cyc) begin
         for (int k = 0; k < LATENCY; k++) p[k].v <= 1'b0;
         cnt <= 4'd0;
      end else begin
         p[0] <= in_t;
         for (int k = 1; k < LATENCY; k++) p[k] <= p[k-1];
         cnt <= cnt + 4'(acc) - 4'(last_in.v);
      end
   end
   // read data is captured together with its ack and held otherwise
   always_ff @(posedge clk_i) begin
      if (rst_i) dat_q <= 32'd0;
      else if (bus.cyc && last_in.v && last_in.r && !last_in.e) dat_q <= last_in.d;
   end
   // byte-lane writes commit on the accept edge
   always_ff @(posedge clk_i) begin
      if (!rst_i && acc && bus.we && !oor)
         for (int i = 0; i < 4; i++)
            if (bus.sel[i]) ram[idx][8*i +: 8] <= bus.dat_m[8*i +: 8];
   end
endmodule
